// File: rtl/ctrl_packet_injector.sv
// Merges queued host control commands into idle gaps of a forward packet stream
// and forwards the backward instruction path with one cycle of latency.
module ctrl_packet_injector #(
    parameter int DATA_WIDTH                  = 512,
    parameter int STREAM_ID_NUM               = 16,
    parameter int CHUNK_ID_NUM                = 32,
    parameter int CHANNEL_ID_NUM              = 1024,
    parameter int STATE_WIDTH                 = 32,
    parameter int INSTRUCTION_WIDTH           = 2,
    parameter int INSTRUCTION_PARAMETER_WIDTH = 16,
    parameter logic [INSTRUCTION_WIDTH-1:0] INSTRUCTION_CMD_RESET = 2'd3,
    parameter int CMD_FIFO_DEPTH              = 4,
    localparam int SW = $clog2(STREAM_ID_NUM),
    localparam int KW = $clog2(CHUNK_ID_NUM),
    localparam int CW = $clog2(CHANNEL_ID_NUM),
    localparam int FW = $clog2(CMD_FIFO_DEPTH) + 1
) (
    input  logic                                   clk,
    input  logic                                   rstIn,
    input  logic [DATA_WIDTH-1:0]                  up_Data,
    input  logic [1:0]                             up_Type,
    input  logic                                   up_Last,
    input  logic [SW-1:0]                          up_StreamID,
    input  logic [KW-1:0]                          up_ChunkID,
    input  logic [CW-1:0]                          up_ChannelID,
    input  logic [STATE_WIDTH-1:0]                 up_State,
    output logic [DATA_WIDTH-1:0]                  dn_Data,
    output logic [1:0]                             dn_Type,
    output logic                                   dn_Last,
    output logic [SW-1:0]                          dn_StreamID,
    output logic [KW-1:0]                          dn_ChunkID,
    output logic [CW-1:0]                          dn_ChannelID,
    output logic [STATE_WIDTH-1:0]                 dn_State,
    input  logic [INSTRUCTION_WIDTH-1:0]           dn_InstructionType,
    input  logic [SW-1:0]                          dn_InstructionStreamID,
    input  logic [CW-1:0]                          dn_InstructionChannelID,
    input  logic [INSTRUCTION_PARAMETER_WIDTH-1:0] dn_InstructionParameter,
    output logic [INSTRUCTION_WIDTH-1:0]           up_InstructionType,
    output logic [SW-1:0]                          up_InstructionStreamID,
    output logic [CW-1:0]                          up_InstructionChannelID,
    output logic [INSTRUCTION_PARAMETER_WIDTH-1:0] up_InstructionParameter,
    input  logic                                   cmd_valid,
    output logic                                   cmd_ready,
    input  logic                                   cmd_write,
    input  logic [CW-1:0]                          cmd_hop,
    input  logic [SW-1:0]                          cmd_streamID,
    input  logic [STATE_WIDTH-1:0]                 cmd_addr,
    input  logic [31:0]                            cmd_data,
    output logic [FW-1:0]                          fifo_level,
    output logic [15:0]                            starve_cnt
);

    localparam int AW = FW - 1;
    localparam logic [FW-1:0] FULL_LEVEL = FW'(CMD_FIFO_DEPTH);

    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [FW-1:0]          count;
    logic                   in_packet;

    logic                   q_write [CMD_FIFO_DEPTH];
    logic [CW-1:0]          q_hop   [CMD_FIFO_DEPTH];
    logic [SW-1:0]          q_sid   [CMD_FIFO_DEPTH];
    logic [STATE_WIDTH-1:0] q_addr  [CMD_FIFO_DEPTH];
    logic [31:0]            q_data  [CMD_FIFO_DEPTH];

    logic                   flush_p0;
    logic                   free_slot_p0;
    logic                   push_p0;
    logic                   vld_p0;
    logic [KW-1:0]          inj_chunk_p0;

    // stage p0: slot detection, queue handshake and injection decision
    assign flush_p0     = (dn_InstructionType == INSTRUCTION_CMD_RESET);
    assign free_slot_p0 = (up_Type == 2'b00) && !in_packet;
    assign vld_p0       = free_slot_p0 && (count != '0) && !flush_p0;
    assign cmd_ready    = !rstIn && (count != FULL_LEVEL) && !flush_p0;
    assign push_p0      = cmd_valid && cmd_ready;
    assign fifo_level   = count;

    always_comb begin
        inj_chunk_p0         = '0;
        inj_chunk_p0[KW-1]   = 1'b1;
        inj_chunk_p0[0]      = q_write[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (push_p0) begin
            q_write[wr_ptr] <= cmd_write;
            q_hop[wr_ptr]   <= cmd_hop;
            q_sid[wr_ptr]   <= cmd_streamID;
            q_addr[wr_ptr]  <= cmd_addr;
            q_data[wr_ptr]  <= cmd_data;
        end
    end

    always_ff @(posedge clk or posedge rstIn) begin
        if (rstIn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            in_packet  <= 1'b0;
            starve_cnt <= '0;
        end else begin
            if (up_Type != 2'b00) begin
                in_packet <= !up_Last;
            end
            if (push_p0) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            // A flush drops everything queued; push is already blocked via cmd_ready.
            if (flush_p0) begin
                rd_ptr <= wr_ptr;
                count  <= '0;
            end else begin
                if (vld_p0) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                if (push_p0 && !vld_p0) begin
                    count <= count + 1'b1;
                end else if (!push_p0 && vld_p0) begin
                    count <= count - 1'b1;
                end
            end
            if (vld_p0 || (count == '0) || flush_p0) begin
                starve_cnt <= '0;
            end else if (!free_slot_p0 && (starve_cnt != 16'hFFFF)) begin
                starve_cnt <= starve_cnt + 16'd1;
            end
        end
    end

    // stage p1: registered forward and backward outputs
    always_ff @(posedge clk or posedge rstIn) begin
        if (rstIn) begin
            dn_Data                 <= '0;
            dn_Type                 <= 2'b00;
            dn_Last                 <= 1'b0;
            dn_StreamID             <= '0;
            dn_ChunkID              <= '0;
            dn_ChannelID            <= '0;
            dn_State                <= '0;
            up_InstructionType      <= '0;
            up_InstructionStreamID  <= '0;
            up_InstructionChannelID <= '0;
            up_InstructionParameter <= '0;
        end else begin
            up_InstructionType      <= dn_InstructionType;
            up_InstructionStreamID  <= dn_InstructionStreamID;
            up_InstructionChannelID <= dn_InstructionChannelID;
            up_InstructionParameter <= dn_InstructionParameter;
            if (vld_p0) begin
                dn_Data      <= {(DATA_WIDTH/32){q_data[rd_ptr]}};
                dn_Type      <= 2'b10;
                dn_Last      <= 1'b1;
                dn_StreamID  <= q_sid[rd_ptr];
                dn_ChunkID   <= inj_chunk_p0;
                dn_ChannelID <= q_hop[rd_ptr];
                dn_State     <= q_addr[rd_ptr];
            end else begin
                dn_Data      <= up_Data;
                dn_Type      <= up_Type;
                dn_Last      <= up_Last;
                dn_StreamID  <= up_StreamID;
                dn_ChunkID   <= up_ChunkID;
                dn_ChannelID <= up_ChannelID;
                dn_State     <= up_State;
            end
        end
    end

endmodule

// File: tb/tb_ctrl_packet_injector.sv
// Scoreboard bench for ctrl_packet_injector: directed stream/command scenarios,
// injected beats checked by an independent monitor against queued expectations.
module tb_ctrl_packet_injector;

    localparam int DW = 512;
    localparam int SW = 4;
    localparam int KW = 5;
    localparam int CW = 10;
    localparam int STW = 32;
    localparam int FW = 3;

    logic           clk = 1'b0;
    logic           rstIn = 1'b0;
    logic [DW-1:0]  up_Data = '0;
    logic [1:0]     up_Type = 2'b00;
    logic           up_Last = 1'b0;
    logic [SW-1:0]  up_StreamID = '0;
    logic [KW-1:0]  up_ChunkID = '0;
    logic [CW-1:0]  up_ChannelID = '0;
    logic [STW-1:0] up_State = '0;
    logic [DW-1:0]  dn_Data;
    logic [1:0]     dn_Type;
    logic           dn_Last;
    logic [SW-1:0]  dn_StreamID;
    logic [KW-1:0]  dn_ChunkID;
    logic [CW-1:0]  dn_ChannelID;
    logic [STW-1:0] dn_State;
    logic [1:0]     dn_InstructionType = '0;
    logic [SW-1:0]  dn_InstructionStreamID = '0;
    logic [CW-1:0]  dn_InstructionChannelID = '0;
    logic [15:0]    dn_InstructionParameter = '0;
    logic [1:0]     up_InstructionType;
    logic [SW-1:0]  up_InstructionStreamID;
    logic [CW-1:0]  up_InstructionChannelID;
    logic [15:0]    up_InstructionParameter;
    logic           cmd_valid = 1'b0;
    logic           cmd_ready;
    logic           cmd_write = 1'b0;
    logic [CW-1:0]  cmd_hop = '0;
    logic [SW-1:0]  cmd_streamID = '0;
    logic [STW-1:0] cmd_addr = '0;
    logic [31:0]    cmd_data = '0;
    logic [FW-1:0]  fifo_level;
    logic [15:0]    starve_cnt;

    ctrl_packet_injector dut (
        .clk(clk), .rstIn(rstIn),
        .up_Data(up_Data), .up_Type(up_Type), .up_Last(up_Last), .up_StreamID(up_StreamID),
        .up_ChunkID(up_ChunkID), .up_ChannelID(up_ChannelID), .up_State(up_State),
        .dn_Data(dn_Data), .dn_Type(dn_Type), .dn_Last(dn_Last), .dn_StreamID(dn_StreamID),
        .dn_ChunkID(dn_ChunkID), .dn_ChannelID(dn_ChannelID), .dn_State(dn_State),
        .dn_InstructionType(dn_InstructionType), .dn_InstructionStreamID(dn_InstructionStreamID),
        .dn_InstructionChannelID(dn_InstructionChannelID), .dn_InstructionParameter(dn_InstructionParameter),
        .up_InstructionType(up_InstructionType), .up_InstructionStreamID(up_InstructionStreamID),
        .up_InstructionChannelID(up_InstructionChannelID), .up_InstructionParameter(up_InstructionParameter),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_hop(cmd_hop),
        .cmd_streamID(cmd_streamID), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .fifo_level(fifo_level), .starve_cnt(starve_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [KW-1:0]  chunk;
        logic [CW-1:0]  hop;
        logic [SW-1:0]  sid;
        logic [STW-1:0] addr;
        logic [31:0]    data;
        int             at;
    } exp_t;

    exp_t sb[$];
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every control beat on the downstream side must match the queue head.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rstIn && dn_Type[1]) begin
            if (sb.size() == 0) begin
                check("unexpected_injection_type", dn_Type, 2'b00);
            end else begin
                e = sb.pop_front();
                check("inj_cycle", cyc, e.at);
                check("inj_type_last", {dn_Type, dn_Last}, 3'b101);
                check("inj_chunk", dn_ChunkID, e.chunk);
                check("inj_channel", dn_ChannelID, e.hop);
                check("inj_stream", dn_StreamID, e.sid);
                check("inj_state", dn_State, e.addr);
                check("inj_data", dn_Data, {16{e.data}});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [1:0] t, input logic l);
        up_Type = t;
        up_Last = l;
        up_Data = {16{32'hBEEF_0000}};
    endtask

    task automatic push(input logic w, input logic [CW-1:0] hop, input logic [SW-1:0] sid,
                        input logic [31:0] addr, input logic [31:0] data, input int at,
                        input bit expect_out);
        cmd_valid    = 1'b1;
        cmd_write    = w;
        cmd_hop      = hop;
        cmd_streamID = sid;
        cmd_addr     = addr;
        cmd_data     = data;
        check("push_ready", cmd_ready, 1'b1);
        if (expect_out)
            sb.push_back('{chunk: (w ? 5'b10001 : 5'b10000), hop: hop, sid: sid,
                           addr: addr, data: data, at: at});
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int t;
        // Reset state
        #1 rstIn = 1'b1;
        #1;
        check("rst_dn_type", dn_Type, 2'b00);
        check("rst_dn_last", dn_Last, 1'b0);
        check("rst_up_instr", up_InstructionType, 2'b00);
        check("rst_fifo_level", fifo_level, 0);
        check("rst_starve", starve_cnt, 0);
        check("rst_cmd_ready", cmd_ready, 1'b0);
        check("rst_dn_data", dn_Data, 0);
        tick();
        tick();
        rstIn = 1'b0;
        tick();

        // Pass-through of both directions
        beat(2'b01, 1'b0);
        up_Data = {16{32'h1111_2222}};
        up_ChannelID = 10'd777; up_StreamID = 4'd9; up_ChunkID = 5'd7; up_State = 32'hCAFE_0001;
        dn_InstructionType = 2'd1; dn_InstructionParameter = 16'h1234;
        dn_InstructionChannelID = 10'd5; dn_InstructionStreamID = 4'd2;
        tick();
        check("pt_type", dn_Type, 2'b01);
        check("pt_last", dn_Last, 1'b0);
        check("pt_channel", dn_ChannelID, 10'd777);
        check("pt_stream", dn_StreamID, 4'd9);
        check("pt_chunk", dn_ChunkID, 5'd7);
        check("pt_state", dn_State, 32'hCAFE_0001);
        check("pt_data", dn_Data, {16{32'h1111_2222}});
        check("bk_type", up_InstructionType, 2'd1);
        check("bk_param", up_InstructionParameter, 16'h1234);
        check("bk_channel", up_InstructionChannelID, 10'd5);
        up_Last = 1'b1; up_ChannelID = 10'd1023;
        dn_InstructionType = 2'd0;
        tick();
        check("pt_last_beat", dn_Last, 1'b1);
        check("pt_channel_max", dn_ChannelID, 10'd1023);
        check("bk_type_clear", up_InstructionType, 2'd0);
        beat(2'b00, 1'b0);
        up_ChannelID = '0; up_StreamID = '0; up_ChunkID = '0; up_State = '0;
        tick();
        check("pt_idle", dn_Type, 2'b00);

        // Write command on an idle stream: injection two cycles after acceptance
        push(1'b1, 10'd3, 4'd5, 32'h10, 32'hA5A5_A5A5, cyc + 2, 1'b1);
        check("wr_level_queued", fifo_level, 1);
        tick();
        check("wr_level_popped", fifo_level, 0);
        check("wr_starve", starve_cnt, 0);
        tick();
        check("wr_back_idle", dn_Type, 2'b00);

        // Read queued inside a 3-beat packet with a gap: waits for the idle after Last
        t = cyc;
        beat(2'b01, 1'b0);
        push(1'b0, 10'd1023, 4'd15, 32'hDEAD_BEEF, 32'h0123_4567, t + 5, 1'b1);
        beat(2'b00, 1'b0);
        tick();
        beat(2'b01, 1'b0);
        tick();
        beat(2'b01, 1'b1);
        tick();
        check("pkt_starve_3", starve_cnt, 3);
        check("pkt_level_held", fifo_level, 1);
        beat(2'b00, 1'b0);
        tick();
        check("pkt_starve_clear", starve_cnt, 0);
        check("pkt_level_popped", fifo_level, 0);
        tick();

        // Fill the queue, overflow attempt, then drain with a concurrent push+pop
        t = cyc;
        beat(2'b01, 1'b0);
        for (int i = 0; i < 4; i++)
            push(1'(i), CW'(i + 1), SW'(i), 32'h100 + 32'(i), 32'hC0DE_0000 + 32'(i), t + 7 + i, 1'b1);
        check("full_ready_low", cmd_ready, 1'b0);
        check("full_level", fifo_level, 4);
        cmd_valid = 1'b1; cmd_data = 32'hBAD0_BAD0;
        tick();
        cmd_valid = 1'b0;
        check("full_level_drop", fifo_level, 4);
        beat(2'b01, 1'b1);
        tick();
        check("full_starve_5", starve_cnt, 5);
        beat(2'b00, 1'b0);
        tick();
        check("drain_level_3", fifo_level, 3);
        push(1'b1, 10'd600, 4'd7, 32'h0000_0ABC, 32'h7777_8888, cyc + 4, 1'b1);
        check("pushpop_level", fifo_level, 3);
        tick();
        tick();
        tick();
        check("drain_level_0", fifo_level, 0);
        tick();

        // Flush: two queued commands dropped on the reset instruction, no injection
        beat(2'b01, 1'b0);
        push(1'b1, 10'd11, 4'd1, 32'h1, 32'h1111_1111, 0, 1'b0);
        push(1'b0, 10'd12, 4'd2, 32'h2, 32'h2222_2222, 0, 1'b0);
        beat(2'b01, 1'b1);
        tick();
        check("flush_level_2", fifo_level, 2);
        beat(2'b00, 1'b0);
        dn_InstructionType = 2'd3;
        #1;
        check("flush_ready_low", cmd_ready, 1'b0);
        tick();
        check("flush_level_0", fifo_level, 0);
        check("flush_no_inject", dn_Type, 2'b00);
        check("flush_fwd_instr", up_InstructionType, 2'd3);
        dn_InstructionType = 2'd0;
        tick();
        check("flush_after_type", dn_Type, 2'b00);
        check("flush_after_instr", up_InstructionType, 2'd0);

        // Long packet: starvation counter saturates, clears on the injection
        t = cyc;
        beat(2'b01, 1'b0);
        push(1'b0, 10'd42, 4'd3, 32'h5555_0000, 32'h0F0F_0F0F, t + 66003, 1'b1);
        repeat (66000) tick();
        check("starve_sat", starve_cnt, 16'hFFFF);
        beat(2'b01, 1'b1);
        tick();
        check("starve_sat_hold", starve_cnt, 16'hFFFF);
        beat(2'b00, 1'b0);
        tick();
        check("starve_clear", starve_cnt, 0);
        tick();

        // Asynchronous reset mid-packet with three queued commands
        beat(2'b01, 1'b0);
        dn_InstructionType = 2'd1;
        push(1'b1, 10'd21, 4'd4, 32'h21, 32'h2121_2121, 0, 1'b0);
        push(1'b1, 10'd22, 4'd4, 32'h22, 32'h2222_2222, 0, 1'b0);
        push(1'b1, 10'd23, 4'd4, 32'h23, 32'h2323_2323, 0, 1'b0);
        check("arst_level_3", fifo_level, 3);
        check("arst_dn_type_pre", dn_Type, 2'b01);
        #3 rstIn = 1'b1;
        #1;
        check("arst_dn_type", dn_Type, 2'b00);
        check("arst_level", fifo_level, 0);
        check("arst_ready", cmd_ready, 1'b0);
        check("arst_up_instr", up_InstructionType, 2'd0);
        check("arst_dn_data", dn_Data, 0);
        tick();
        rstIn = 1'b0;
        beat(2'b00, 1'b0);
        dn_InstructionType = 2'd0;
        repeat (5) tick();
        check("arst_after_level", fifo_level, 0);
        check("arst_after_type", dn_Type, 2'b00);

        check("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ctrl_packet_injector.md
CTRL_PACKET_INJECTOR -- requirements
Module: ctrl_packet_injector

Interface
REQ-001 Parameters (name, default, meaning): DATA_WIDTH 512 data bus width, a multiple of 32; STREAM_ID_NUM 16; CHUNK_ID_NUM 32; CHANNEL_ID_NUM 1024; STATE_WIDTH 32; INSTRUCTION_WIDTH 2; INSTRUCTION_PARAMETER_WIDTH 16; INSTRUCTION_CMD_RESET 2'd3; CMD_FIFO_DEPTH 4, a power of 2.
REQ-002 Derived widths: SW=$clog2(STREAM_ID_NUM), KW=$clog2(CHUNK_ID_NUM), CW=$clog2(CHANNEL_ID_NUM), FW=$clog2(CMD_FIFO_DEPTH)+1.
REQ-003 clk  in  1  single clock; all state changes on the rising edge.
REQ-004 rstIn  in  1  asynchronous, active-high reset.
REQ-005 up_Data/Type/Last/StreamID/ChunkID/ChannelID/State  in  DATA_WIDTH/2/1/SW/KW/CW/STATE_WIDTH  upstream forward stream.
REQ-006 dn_Data/Type/Last/StreamID/ChunkID/ChannelID/State  out  same widths  registered forward stream to the downstream module.
REQ-007 dn_InstructionType/StreamID/ChannelID/Parameter  in  INSTRUCTION_WIDTH/SW/CW/INSTRUCTION_PARAMETER_WIDTH  backward instruction from downstream.
REQ-008 up_InstructionType/StreamID/ChannelID/Parameter  out  same widths  registered backward instruction to upstream.
REQ-009 cmd_valid in 1; cmd_ready out 1; cmd_write in 1 (1=write, 0=read request); cmd_hop in CW; cmd_streamID in SW; cmd_addr in STATE_WIDTH; cmd_data in 32: host control-command handshake.
REQ-010 fifo_level  out  FW  number of queued commands.
REQ-011 starve_cnt  out  16  consecutive cycles with a non-empty queue and no free slot, saturating.

Function
REQ-012 Type encoding: bit1 marks a control packet, bit0 marks a data packet, 2'b00 marks an idle beat.
REQ-013 Pass-through has 1-cycle latency: every non-injected cycle, dn_* SHALL equal the previous cycle's up_*, including ChannelID unmodified.
REQ-014 Backward path: up_Instruction* SHALL equal the previous cycle's dn_Instruction* on every cycle, 1-cycle latency.
REQ-015 inPacket flag: set when up_Type!=0 and up_Last=0; cleared when up_Type!=0 and up_Last=1; unchanged when up_Type=0.
REQ-016 Free slot: up_Type==0 AND inPacket==0, evaluated on the current-cycle inPacket value before that cycle's update.
REQ-017 Injection: on a free slot with the queue non-empty, the next cycle SHALL drive the following and pop the queue head:
- dn_Type=2'b10, dn_Last=1
- dn_ChunkID={1'b1, opcode}, opcode (KW-1 bits) = 1 for write, 0 for read request
- dn_ChannelID=cmd_hop, dn_StreamID=cmd_streamID, dn_State=cmd_addr
- dn_Data = cmd_data replicated into all DATA_WIDTH/32 fields
REQ-018 At most one command is injected per free slot; back-to-back free slots inject back-to-back commands in FIFO order.
REQ-019 cmd_ready = (fifo_level<CMD_FIFO_DEPTH) AND (dn_InstructionType!=INSTRUCTION_CMD_RESET), combinational.
REQ-020 Push on cmd_valid&&cmd_ready; a pushed command is eligible from the following cycle, so minimum acceptance-to-dn_Type latency is 2 cycles.
REQ-021 A simultaneous push and pop SHALL leave fifo_level unchanged; FIFO pointers wrap modulo CMD_FIFO_DEPTH.
REQ-022 Flush: when dn_InstructionType==INSTRUCTION_CMD_RESET, the queue SHALL be emptied at that edge and no injection SHALL occur that cycle; the instruction is still forwarded per REQ-014.
REQ-023 starve_cnt increments each cycle with fifo_level>0 and no free slot; it clears on any injection or when the queue is empty, and saturates at 16'hFFFF.

Reset
REQ-024 While rstIn=1, the block SHALL drive: dn_Type=0, dn_Last=0, up_InstructionType=0, fifo_level=0, starve_cnt=0, inPacket=0, queue empty, cmd_ready=0.
REQ-025 Other dn_*/up_Instruction* data fields SHALL reset to 0.
REQ-026 Reset asserted mid-packet or with a non-empty queue SHALL discard all queued commands and the inPacket state.

Verification
REQ-027 Idle stream, push write (hop=3, addr=0x10, data=0xA5A5A5A5) at cycle t -> at t+2 dn_Type=2'b10, dn_ChunkID=5'b10001, dn_ChannelID=3, dn_State=0x10, all 16 data words =0xA5A5A5A5.
REQ-028 Upstream 3-beat data packet (Last on beat 3) with an idle gap after beat 1, queued read -> no injection inside the packet; injection on the first idle beat after Last, dn_ChunkID=5'b10000.
REQ-029 Push 5 commands with no free slots -> cmd_ready falls after the 4th push, fifo_level=4; 4 idle cycles -> 4 consecutive injections in order, fifo_level=0.
REQ-030 Queue of 2 plus dn_InstructionType=3 for one cycle -> fifo_level=0 next cycle, no injection, up_InstructionType=3 one cycle later.
REQ-031 Continuous data beats for 70000 cycles with 1 queued command -> starve_cnt=16'hFFFF; first idle slot -> injection, starve_cnt=0.
REQ-032 rstIn asserted asynchronously mid-packet with 3 commands queued -> outputs take reset values immediately; after release, the idle stream produces no injection.
